// File: rtl/basic_axis_pkg.sv
// Shared types and helpers for the basic_axis stream stages.
// Beat bundle layout and lane-count arithmetic live here.
package basic_axis_pkg;

    localparam int DEF_TDATA_W = 512;
    localparam int DEF_ADDER_W = 32;
    localparam int DEF_CNT_W   = 32;

    function automatic int lane_count(input int dw, input int aw);
        return dw / aw;
    endfunction

    typedef struct packed {
        logic [DEF_TDATA_W-1:0]   tdata;
        logic [DEF_TDATA_W/8-1:0] tkeep;
        logic                     tlast;
    } beat_t;

endpackage

// File: rtl/basic_axis_skid_buffer.sv
// Two-entry OUT/SKID register pair for a valid/ready stream.
// Ready is registered so no path exists from out_ready to in_ready.
module basic_axis_skid_buffer #(
    parameter int W = 577
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         ready_q;
    logic         skid_valid;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         drain;

    assign in_ready = ready_q && !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // OUT/SKID occupancy: refill OUT from SKID first, else from input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else begin
            ready_q <= 1'b1;
            if (drain) begin
                if (skid_valid) begin
                    out_data   <= skid_q;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                if (!out_valid) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                end else begin
                    skid_q     <= in_data;
                    skid_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/basic_axis_lane_adder.sv
// Adds a per-packet constant to every fully-kept lane of each beat.
// Registered skid output stage plus saturating beat/packet counters.
module basic_axis_lane_adder
    import basic_axis_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = DEF_TDATA_W,
    parameter int C_ADDER_BIT_WIDTH  = DEF_ADDER_W,
    parameter int C_CNT_WIDTH        = DEF_CNT_W
) (
    input  logic                            axis_aclk,
    input  logic                            axis_aresetn,
    input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_constant,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [C_CNT_WIDTH-1:0]          stat_beats,
    output logic [C_CNT_WIDTH-1:0]          stat_packets
);

    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int AW = C_ADDER_BIT_WIDTH;
    localparam int KW = DW / 8;
    localparam int LB = AW / 8;
    localparam int N  = lane_count(DW, AW);
    localparam int BW = DW + KW + 1;

    logic          accept;
    logic          in_pkt;
    logic [AW-1:0] const_q;
    logic [AW-1:0] k;
    logic [DW-1:0] sum;
    logic [BW-1:0] out_beat;
    logic          m_hs;

    assign accept = s_axis_tvalid && s_axis_tready;
    assign k      = in_pkt ? const_q : ctrl_constant;
    assign m_hs   = m_axis_tvalid && m_axis_tready;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic full;
        assign full = &s_axis_tkeep[i*LB +: LB];
        assign sum[i*AW +: AW] = full ? s_axis_tdata[i*AW +: AW] + k
                                      : s_axis_tdata[i*AW +: AW];
    end

    // Packet tracking: latch the addend on the first beat of a packet
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            in_pkt  <= 1'b0;
            const_q <= '0;
        end else if (accept) begin
            in_pkt <= !s_axis_tlast;
            if (!in_pkt) const_q <= ctrl_constant;
        end
    end

    basic_axis_skid_buffer #(
        .W (BW)
    ) u_skid (
        .clk       (axis_aclk),
        .rst_n     (axis_aresetn),
        .in_valid  (s_axis_tvalid),
        .in_ready  (s_axis_tready),
        .in_data   ({s_axis_tlast, s_axis_tkeep, sum}),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (out_beat)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_beat;

    // Saturating output-side statistics
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            stat_beats   <= '0;
            stat_packets <= '0;
        end else if (m_hs) begin
            if (stat_beats != '1) stat_beats <= stat_beats + 1'b1;
            if (m_axis_tlast && stat_packets != '1)
                stat_packets <= stat_packets + 1'b1;
        end
    end

endmodule

// File: tb/tb_basic_axis_lane_adder.sv
// Directed and randomized stimulus for basic_axis_lane_adder.
// Expected beats are queued by the bench and matched at the output.
module tb_basic_axis_lane_adder;

    localparam int DW = 512;
    localparam int AW = 32;
    localparam int KW = 64;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] ctrl_constant;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [31:0]   stat_beats;
    logic [31:0]   stat_packets;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] kp;
        logic          l;
    } exp_t;

    exp_t          expq[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            rdy_mode = 0;
    logic          m_in_pkt;
    logic [AW-1:0] m_const;
    logic          stall_v = 1'b0;
    logic [DW-1:0] stall_d;

    always #5 clk = ~clk;

    basic_axis_lane_adder dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rstn),
        .ctrl_constant (ctrl_constant),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .stat_beats    (stat_beats),
        .stat_packets  (stat_packets)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d,
                                            input logic [KW-1:0] kp,
                                            input logic [AW-1:0] k);
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (&kp[i*4 +: 4]) r[i*AW +: AW] = d[i*AW +: AW] + k;
            else r[i*AW +: AW] = d[i*AW +: AW];
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] kp,
                        input logic l, input logic [AW-1:0] c,
                        input logic [DW-1:0] exp_d);
        int n;
        exp_t e;
        e.d = exp_d;
        e.kp = kp;
        e.l = l;
        expq.push_back(e);
        if (!m_in_pkt) m_const = c;
        m_in_pkt = !l;
        ctrl_constant = c;
        s_axis_tdata = d;
        s_axis_tkeep = kp;
        s_axis_tlast = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        while (!s_axis_tready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("accept_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || m_axis_tvalid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", n < 3000, 1'b1);
    endtask

    // downstream ready pattern
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = ($urandom_range(0, 3) != 0);
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // output scoreboard and stall-stability monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (stall_v && rstn) begin
                chk("hold_valid", m_axis_tvalid, 1'b1);
                chk("hold_data", m_axis_tdata, stall_d);
            end
            stall_v = rstn && m_axis_tvalid && !m_axis_tready;
            stall_d = m_axis_tdata;
            if (rstn && m_axis_tvalid && m_axis_tready) begin
                if (expq.size() == 0) begin
                    chk("extra_beat", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", m_axis_tdata, e.d);
                    chk("out_keep", m_axis_tkeep, e.kp);
                    chk("out_last", m_axis_tlast, e.l);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] x;
        logic [DW-1:0] b0x;
        logic [KW-1:0] kp;
        logic [AW-1:0] c;
        int left;
        int len;
        rstn = 1'b0;
        ctrl_constant = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tlast = 1'b0;
        m_in_pkt = 1'b0;
        m_const = '0;
        #1;
        chk("rst_s_ready", s_axis_tready, 1'b0);
        chk("rst_m_valid", m_axis_tvalid, 1'b0);
        chk("rst_m_data", m_axis_tdata, '0);
        chk("rst_beats", stat_beats, '0);
        chk("rst_pkts", stat_packets, '0);
        idle(3);
        rstn = 1'b1;
        chk("rel_ready_lo", s_axis_tready, 1'b0);
        idle(1);
        chk("rel_ready_hi", s_axis_tready, 1'b1);

        // wraparound per lane, no inter-lane carry
        for (int i = 0; i < N; i++) begin
            d[i*AW +: AW] = 32'hFFFF_FFFE;
            x[i*AW +: AW] = 32'h0000_0003;
        end
        send(d, '1, 1'b1, 32'd5, x);
        wait_drain();
        chk("t1_beats", stat_beats, 32'd1);
        chk("t1_pkts", stat_packets, 32'd1);

        // partial lane 0 passes through
        for (int i = 0; i < N; i++) begin
            d[i*AW +: AW] = 10 * (i + 1);
            x[i*AW +: AW] = (i == 0) ? 32'd10 : 10 * (i + 1) + 1;
        end
        send(d, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 32'd1, x);
        wait_drain();

        // constant change mid-packet ignored
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) begin
                d[i*AW +: AW] = 100 * b + i;
                x[i*AW +: AW] = 100 * b + i + 7;
            end
            send(d, '1, b == 3, (b == 0) ? 32'd7 : 32'd9, x);
        end
        for (int i = 0; i < N; i++) begin
            d[i*AW +: AW] = 1000 + i;
            x[i*AW +: AW] = 1009 + i;
        end
        send(d, '1, 1'b1, 32'd9, x);
        wait_drain();
        chk("t3_beats", stat_beats, 32'd7);
        chk("t3_pkts", stat_packets, 32'd4);

        // back-pressure: OUT + SKID fill, then release
        rdy_mode = 2;
        idle(2);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) d[i*AW +: AW] = 500 + 16 * b + i;
            x = model(d, '1, 32'd2);
            if (b == 0) b0x = x;
            if (b < 2) send(d, '1, 1'b1, 32'd2, x);
        end
        chk("bp_ready_lo", s_axis_tready, 1'b0);
        chk("bp_out_valid", m_axis_tvalid, 1'b1);
        chk("bp_out_head", m_axis_tdata, b0x);
        fork
            begin
                for (int b = 2; b < 4; b++) begin
                    for (int i = 0; i < N; i++)
                        d[i*AW +: AW] = 500 + 16 * b + i;
                    send(d, '1, 1'b1, 32'd2, model(d, '1, 32'd2));
                end
            end
            begin
                idle(1);
                chk("bp_ready_hold", s_axis_tready, 1'b0);
                rdy_mode = 0;
            end
        join
        wait_drain();
        chk("bp_beats", stat_beats, 32'd11);
        chk("bp_pkts", stat_packets, 32'd8);

        // randomized traffic against the model
        rstn = 1'b0;
        expq.delete();
        m_in_pkt = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(1);
        rdy_mode = 1;
        left = 1000;
        while (left > 0) begin
            len = $urandom_range(1, 8);
            for (int b = 0; b < len && left > 0; b++) begin
                for (int i = 0; i < N; i++) begin
                    d[i*AW +: AW] = $urandom;
                    kp[i*4 +: 4] = ($urandom_range(0, 3) == 0) ?
                                   4'($urandom) : 4'hF;
                end
                c = $urandom;
                x = model(d, kp, m_in_pkt ? m_const : c);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
                send(d, kp, (b == len - 1) || (left == 1), c, x);
                left--;
            end
        end
        wait_drain();
        chk("rand_beats", stat_beats, 32'd1000);

        // reset mid-packet with OUT and SKID occupied
        rdy_mode = 2;
        idle(2);
        for (int i = 0; i < N; i++) d[i*AW +: AW] = i;
        send(d, '1, 1'b0, 32'd3, model(d, '1, 32'd3));
        send(d, '1, 1'b0, 32'd3, model(d, '1, 32'd3));
        rstn = 1'b0;
        #1;
        chk("mr_m_valid", m_axis_tvalid, 1'b0);
        chk("mr_m_data", m_axis_tdata, '0);
        chk("mr_m_keep", m_axis_tkeep, '0);
        chk("mr_s_ready", s_axis_tready, 1'b0);
        chk("mr_beats", stat_beats, '0);
        expq.delete();
        m_in_pkt = 1'b0;
        rdy_mode = 0;
        idle(2);
        rstn = 1'b1;
        chk("mr_rel_lo", s_axis_tready, 1'b0);
        idle(1);
        chk("mr_rel_hi", s_axis_tready, 1'b1);
        for (int i = 0; i < N; i++) x[i*AW +: AW] = i + 11;
        send(d, '1, 1'b1, 32'd11, x);
        wait_drain();
        chk("mr_beats_after", stat_beats, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
